clk_enable_ctrl: RTL and testbench
==================================

# clk_enable_ctrl

Run-time programmable clock-enable controller for the Proyecto1 datapath. It owns a divisor register and a modulo counter, and emits a one-cycle `tick` enable plus a square `phase_out` level. It accepts new divisors over a valid/ready handshake and applies them only at a period boundary, so downstream blocks (VGA timing, slow peripherals) never see a truncated or stretched period. It replaces fixed compile-time dividers wherever software or the control unit must change the rate.

## Interface
- `W`, 8: divisor/counter width in bits.
- `DEFAULT_DIV`, 4: divisor loaded at reset (25 MHz enable from 100 MHz); must be in 1..2^W-1.

- `clk_in`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `run`  in  1  level; 1 = counting, 0 = stopped.
- `cfg_valid`  in  1  new divisor offered.
- `cfg_div`  in  W  offered divisor; 0 is coerced to 1.
- `cfg_ready`  out  1  controller can accept a divisor.
- `tick`  out  1  one-cycle enable, once per period.
- `phase_out`  out  1  square-ish level, high in the second half of each period.
- `busy`  out  1  a divisor is pending, waiting for a period boundary.
- `div_cur`  out  W  divisor currently in effect.

## Operation
- Registers:
  - `state` ∈ {STOP, RUN, PEND}.
  - `cnt[W-1:0]`.
  - `div_cur`.
  - `div_pend`.
  - `tick` (registered).
- Reset values:
  - `state` = STOP, `cnt` = 0, `div_cur` = DEFAULT_DIV, `div_pend` = DEFAULT_DIV.
  - `tick` = 0, `cfg_ready` = 1, `busy` = 0, `phase_out` = 0.
- Handshake: a transfer occurs on an edge where `cfg_valid && cfg_ready`. `cfg_div` is sampled only then. `cfg_ready = (state != PEND)`.
- Wrap: the condition `cnt == div_cur-1` while in RUN or PEND.
  - On wrap, `cnt` <= 0; otherwise `cnt` <= `cnt` + 1.
  - `tick` <= wrap.
- `phase_out = (state != STOP) && (cnt >= (div_cur >> 1))`, derived from registers only.
  - `div_cur` = 1: `phase_out` is constant 1 while running.
- STOP:
  - `cnt` held at 0 and `tick` = 0.
  - A transfer loads `div_cur` directly, effective next cycle.
  - `run` = 1 -> RUN.
  - Transfer and `run` rising on the same edge: the new divisor governs the first period.
- RUN:
  - The counter runs.
  - A transfer loads `div_pend` -> PEND, so `busy` = 1 and `cfg_ready` = 0 from the next cycle.
- PEND:
  - The counter keeps running with the old `div_cur`.
  - On wrap: `div_cur` <= `div_pend`, `cnt` <= 0, -> RUN. The tick for that wrap is still emitted.
- `run` = 0 in RUN or PEND:
  - -> STOP next edge, `cnt` <= 0, `tick` <= 0.
  - Any pending divisor is applied to `div_cur` immediately and `busy` clears.
  - `run` = 0 has priority over wrap and over a simultaneous transfer; the transfer is still accepted if `cfg_ready` was 1.
- Arithmetic:
  - `cnt` compare is W bits unsigned.
  - The coercion 0 -> 1 is done at capture.
  - `cnt` never exceeds `div_cur`-1, since the divisor only changes at `cnt` = 0 or while stopped.

## Timing
- Period is exactly `div_cur` cycles.
  - With `run` rising at edge 0 (cnt = 0 in cycle 0), `tick` is high in cycles `div_cur`, 2·`div_cur`, and so on.
- Tick latency from the wrap cycle: 1 cycle (registered).
- Config latency:
  - In STOP: 1 cycle.
  - In RUN: takes effect at the next boundary, worst case `div_cur` cycles. `busy` is high from the cycle after the transfer until the cycle after the wrap.
- `rst` mid-operation returns all registers to reset values on that edge. A pending divisor is discarded and `div_cur` = DEFAULT_DIV.
- No combinational path from inputs to outputs.

## Test plan
- Reset, then `run` = 1 with default 4:
  - `tick` pulses every 4 cycles, first in cycle 4.
  - `phase_out` = 0,0,1,1 repeating.
  - `cfg_ready` = 1 and `busy` = 0 throughout.
- In STOP, write `cfg_div` = 7 together with `run` rising: `div_cur` = 7 next cycle and the first tick arrives at cycle 7.
- While running with div 4 at `cnt` = 1, write 10:
  - `busy` = 1 and `cfg_ready` = 0.
  - Ticks follow at the old 4-cycle spacing until the boundary, then at 10-cycle spacing.
  - A second `cfg_valid` during PEND is not accepted.
- Write `cfg_div` = 0, then `cfg_div` = 1:
  - `div_cur` reads 1 in both cases.
  - `tick` is high every cycle while running.
  - `phase_out` is constant 1.
- Drop `run` while in PEND (div 8 pending 3): STOP next cycle, `div_cur` = 3, `busy` = 0, `tick` = 0, `cnt` = 0.
- Assert `rst` mid-period while in PEND: all outputs return to reset values next cycle, `div_cur` = 4, and the pending value is lost.

Source files
------------

// File: rtl/clk_enable_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : clk_enable_ctrl_if
// Purpose  : Bundles the control, configuration handshake and status signals
//            of clk_enable_ctrl.
// Ports    : run, cfg_valid, cfg_div        -> controller (master drives)
//            cfg_ready, tick, phase_out,
//            busy, div_cur                  <- controller (slave drives)
// Revision : 1.0 - initial release
// ============================================================================
interface clk_enable_ctrl_if #(
  parameter int W = 8
);
  logic         run;
  logic         cfg_valid;
  logic [W-1:0] cfg_div;
  logic         cfg_ready;
  logic         tick;
  logic         phase_out;
  logic         busy;
  logic [W-1:0] div_cur;

  modport master (
    output run, cfg_valid, cfg_div,
    input  cfg_ready, tick, phase_out, busy, div_cur
  );

  modport slave (
    input  run, cfg_valid, cfg_div,
    output cfg_ready, tick, phase_out, busy, div_cur
  );
endinterface
`default_nettype wire

// File: rtl/clk_enable_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clk_enable_ctrl
// Purpose  : Run-time programmable clock-enable generator. A modulo counter
//            produces a one-cycle tick every div_cur cycles and a phase level
//            that is high in the second half of each period. New divisors
//            arrive over a valid/ready handshake and only take effect at a
//            period boundary (or immediately while stopped).
// Ports    : clk_in - system clock, rising edge
//            rst    - synchronous active-high reset
//            bus    - clk_enable_ctrl_if slave (run, cfg_valid/cfg_div/
//                     cfg_ready, tick, phase_out, busy, div_cur)
// Revision : 1.0 - initial release
// ============================================================================
module clk_enable_ctrl #(
  parameter int W           = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  wire                 clk_in,
  input  wire                 rst,
  clk_enable_ctrl_if.slave    bus
);

  localparam logic [1:0] STOP = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] PEND = 2'd2;

  localparam logic [W-1:0] DIV_RESET = W'(DEFAULT_DIV);
  localparam logic [W-1:0] ONE       = W'(1);

  logic [1:0]   state;
  logic [1:0]   state_next;
  logic [W-1:0] cnt;
  logic [W-1:0] div_cur_r;
  logic [W-1:0] div_pend;
  logic         tick_r;

  logic         xfer;
  logic         wrap;
  logic [W-1:0] cap_div;

  // cfg_ready is a function of the state register, so the handshake has no
  // combinational input-to-output path.
  assign xfer    = bus.cfg_valid && (state != PEND);
  // A zero divisor would never wrap; coerce it at capture time.
  assign cap_div = (bus.cfg_div == '0) ? ONE : bus.cfg_div;
  assign wrap    = (state != STOP) && (cnt == div_cur_r - ONE);

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk_in) begin
    if (rst) state <= STOP;
    else     state <= state_next;
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    state_next = state;
    case (state)
      STOP:    if (bus.run) state_next = RUN;
      RUN: begin
        if (!bus.run)  state_next = STOP;
        else if (xfer) state_next = PEND;
      end
      PEND: begin
        if (!bus.run)  state_next = STOP;
        else if (wrap) state_next = RUN;
      end
      default: state_next = STOP;
    endcase
  end

  // ------------------------------------------------------------------ outputs
  always_comb begin
    bus.cfg_ready = (state != PEND);
    bus.busy      = (state == PEND);
    bus.phase_out = (state != STOP) && (cnt >= (div_cur_r >> 1));
    bus.tick      = tick_r;
    bus.div_cur   = div_cur_r;
  end

  // ----------------------------------------------------------------- datapath
  always_ff @(posedge clk_in) begin
    if (rst) begin
      cnt       <= '0;
      div_cur_r <= DIV_RESET;
      div_pend  <= DIV_RESET;
      tick_r    <= 1'b0;
    end else if (state == STOP) begin
      cnt    <= '0;
      tick_r <= 1'b0;
      // Loading here lets a transfer on the run-rising edge govern the
      // very first period.
      if (xfer) div_cur_r <= cap_div;
    end else if (!bus.run) begin
      // Stopping wins over wrap; whatever divisor is waiting (or is being
      // accepted on this same edge) becomes current right away.
      cnt    <= '0;
      tick_r <= 1'b0;
      if (state == PEND) div_cur_r <= div_pend;
      else if (xfer)     div_cur_r <= cap_div;
    end else begin
      cnt    <= wrap ? '0 : cnt + ONE;
      tick_r <= wrap;
      if (state == RUN && xfer)  div_pend  <= cap_div;
      if (state == PEND && wrap) div_cur_r <= div_pend;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_clk_enable_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_enable_ctrl
// Purpose  : Directed self-checking bench for clk_enable_ctrl. Expected values
//            are hand-derived from the cycle numbering where cycle 0 is the
//            first cycle after run is sampled high.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_enable_ctrl;

  localparam int W = 8;

  logic clk_in = 1'b0;
  logic rst    = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  clk_enable_ctrl_if #(.W(W)) bus ();

  clk_enable_ctrl #(.W(W), .DEFAULT_DIV(4)) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .bus    (bus.slave)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check_idle(input string tag, input int exp_div);
    check({tag, " tick"},  int'(bus.tick), 0);
    check({tag, " phase"}, int'(bus.phase_out), 0);
    check({tag, " ready"}, int'(bus.cfg_ready), 1);
    check({tag, " busy"},  int'(bus.busy), 0);
    check({tag, " div"},   int'(bus.div_cur), exp_div);
  endtask

  initial begin
    bus.run       = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_div   = '0;

    // ---- reset
    step();
    step();
    rst = 1'b0;
    check_idle("reset", 4);

    // ---- default divisor 4
    bus.run = 1'b1;
    step();
    for (int c = 0; c < 12; c++) begin
      check($sformatf("d4 tick c%0d", c),  int'(bus.tick), (c > 0 && c % 4 == 0) ? 1 : 0);
      check($sformatf("d4 phase c%0d", c), int'(bus.phase_out), (c % 4 >= 2) ? 1 : 0);
      check($sformatf("d4 ready c%0d", c), int'(bus.cfg_ready), 1);
      check($sformatf("d4 busy c%0d", c),  int'(bus.busy), 0);
      step();
    end

    // ---- load 7 in STOP together with run rising
    bus.run = 1'b0;
    step();
    check_idle("stop1", 4);
    bus.run       = 1'b1;
    bus.cfg_valid = 1'b1;
    bus.cfg_div   = 8'd7;
    step();
    bus.cfg_valid = 1'b0;
    for (int c = 0; c < 9; c++) begin
      check($sformatf("d7 div c%0d", c),  int'(bus.div_cur), 7);
      check($sformatf("d7 tick c%0d", c), int'(bus.tick), (c == 7) ? 1 : 0);
      step();
    end

    // ---- running at 4, write 10 at cnt=1, second write during PEND ignored
    bus.run = 1'b0;
    step();
    bus.run       = 1'b1;
    bus.cfg_valid = 1'b1;
    bus.cfg_div   = 8'd4;
    step();                       // cycle 0
    bus.cfg_valid = 1'b0;
    check("pend setup div", int'(bus.div_cur), 4);
    step();                       // cycle 1, cnt = 1
    bus.cfg_valid = 1'b1;
    bus.cfg_div   = 8'd10;
    step();                       // cycle 2
    for (int c = 2; c < 16; c++) begin
      check($sformatf("pend busy c%0d", c),  int'(bus.busy), (c < 4) ? 1 : 0);
      check($sformatf("pend ready c%0d", c), int'(bus.cfg_ready), (c < 4) ? 0 : 1);
      check($sformatf("pend tick c%0d", c),  int'(bus.tick), (c == 4 || c == 14) ? 1 : 0);
      check($sformatf("pend div c%0d", c),   int'(bus.div_cur), (c < 4) ? 4 : 10);
      bus.cfg_valid = (c == 2);
      bus.cfg_div   = 8'd5;
      step();
    end
    bus.cfg_valid = 1'b0;

    // ---- divisor 0 coerced to 1, then 1
    bus.run = 1'b0;
    step();
    bus.cfg_valid = 1'b1;
    bus.cfg_div   = 8'd0;
    step();
    bus.cfg_valid = 1'b0;
    check("div0 coerced", int'(bus.div_cur), 1);
    bus.run = 1'b1;
    step();                       // cycle 0
    for (int c = 0; c < 5; c++) begin
      check($sformatf("d1 tick c%0d", c),  int'(bus.tick), (c > 0) ? 1 : 0);
      check($sformatf("d1 phase c%0d", c), int'(bus.phase_out), 1);
      step();
    end
    bus.run = 1'b0;
    step();
    bus.cfg_valid = 1'b1;
    bus.cfg_div   = 8'd1;
    step();
    bus.cfg_valid = 1'b0;
    check("div1 loaded", int'(bus.div_cur), 1);

    // ---- drop run in PEND (div 8 pending 3)
    bus.cfg_valid = 1'b1;
    bus.cfg_div   = 8'd8;
    bus.run       = 1'b1;
    step();                       // cycle 0
    bus.cfg_valid = 1'b0;
    step();
    step();                       // cycle 2
    bus.cfg_valid = 1'b1;
    bus.cfg_div   = 8'd3;
    step();                       // cycle 3
    bus.cfg_valid = 1'b0;
    check("pend8 busy", int'(bus.busy), 1);
    check("pend8 div",  int'(bus.div_cur), 8);
    bus.run = 1'b0;
    step();
    check_idle("drop", 3);
    bus.run = 1'b1;
    step();                       // cycle 0, counter restarted from 0
    for (int c = 0; c < 7; c++) begin
      check($sformatf("d3 tick c%0d", c),  int'(bus.tick), (c == 3 || c == 6) ? 1 : 0);
      check($sformatf("d3 phase c%0d", c), int'(bus.phase_out), (c % 3 >= 1) ? 1 : 0);
      step();
    end

    // ---- reset while PEND discards the pending divisor
    bus.cfg_valid = 1'b1;
    bus.cfg_div   = 8'd9;
    step();
    bus.cfg_valid = 1'b0;
    check("rst pre busy", int'(bus.busy), 1);
    rst = 1'b1;
    step();
    check_idle("rst mid", 4);
    rst = 1'b0;
    step();                       // cycle 0 with default divisor
    for (int c = 0; c < 10; c++) begin
      check($sformatf("post rst tick c%0d", c), int'(bus.tick), (c == 4 || c == 8) ? 1 : 0);
      check($sformatf("post rst div c%0d", c),  int'(bus.div_cur), 4);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
